// File: rtl/sdma_rdata_pack.sv
// Source-port read-data steering and AHB-to-cache-width packing stage.
// One source is selected per transfer; output is buffered in a 2-entry FIFO.
module sdma_rdata_pack #(
   parameter int unsigned AHB_DW   = 32,
   parameter int unsigned CACHE_DW = 128,
   parameter int unsigned NPORT    = 4,
   parameter int unsigned PID_W    = 3
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic                        i_start,
   input  logic [PID_W-1:0]            i_inst_srcportid,
   input  logic                        i_flush,
   input  logic [AHB_DW-1:0]           i_sdma_ahbrdata,
   input  logic [AHB_DW/8-1:0]         i_sdma_ahbrvld,
   input  logic [NPORT*CACHE_DW-1:0]   i_sdma_crdata,
   input  logic [NPORT*CACHE_DW/8-1:0] i_sdma_crvld,
   output logic                        o_sdma_rrdy,
   output logic [CACHE_DW-1:0]         o_sdma_sportrdata,
   output logic [CACHE_DW/8-1:0]       o_sdma_sportrvld,
   output logic                        o_sdma_sportvalid,
   input  logic                        i_sdma_sportready,
   output logic                        o_sdma_busy,
   output logic                        o_sdma_done,
   output logic                        o_sdma_iderr
);

   localparam int unsigned RATIO = CACHE_DW / AHB_DW;
   localparam int unsigned PTR_W = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam int unsigned AHB_BW = AHB_DW / 8;
   localparam int unsigned CACHE_BW = CACHE_DW / 8;

   typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

   state_e                r_state, w_state_d;
   logic [PID_W-1:0]      r_pid;
   logic [PTR_W-1:0]      r_ptr;
   logic [CACHE_DW-1:0]   r_pack_data;
   logic [CACHE_BW-1:0]   r_pack_vld;
   logic [CACHE_DW-1:0]   r_fifo_data [2];
   logic [CACHE_BW-1:0]   r_fifo_vld [2];
   logic                  r_wr;
   logic                  r_rd;
   logic [1:0]            r_count;
   logic                  r_iderr;

   logic                  w_id_legal;
   logic                  w_is_ahb;
   logic [CACHE_DW-1:0]   w_c_data;
   logic [CACHE_BW-1:0]   w_c_vld;
   logic                  w_src_any;
   logic                  w_accept;
   logic                  w_ahb_acc;
   logic                  w_wrap;
   logic [CACHE_DW-1:0]   w_pack_data;
   logic [CACHE_BW-1:0]   w_pack_vld;
   logic [PTR_W-1:0]      w_ptr_d;
   logic                  w_ending;
   logic                  w_part_push;
   logic                  w_push;
   logic                  w_pop;
   logic [CACHE_DW-1:0]   w_push_data;
   logic [CACHE_BW-1:0]   w_push_vld;
   logic                  w_start_ok;

   always_comb begin
      w_id_legal = (i_inst_srcportid == '0);
      w_c_data   = '0;
      w_c_vld    = '0;
      for (int k = 0; k < int'(NPORT); k++) begin
         if (i_inst_srcportid == PID_W'(4 + k)) w_id_legal = 1'b1;
         if (r_pid == PID_W'(4 + k)) begin
            w_c_data = i_sdma_crdata[k*CACHE_DW +: CACHE_DW];
            w_c_vld  = i_sdma_crvld[k*CACHE_BW +: CACHE_BW];
         end
      end
      w_is_ahb   = (r_pid == '0);
      w_src_any  = w_is_ahb ? (|i_sdma_ahbrvld) : (|w_c_vld);
      w_start_ok = (r_state == StIdle) && i_start && w_id_legal;

      o_sdma_rrdy = (r_state == StRun) && (r_count < 2'd2);
      w_accept    = w_src_any && o_sdma_rrdy;
      w_ahb_acc   = w_accept && w_is_ahb;

      // Pack register view after this cycle's beat lands in lane r_ptr.
      w_pack_data = r_pack_data;
      w_pack_vld  = r_pack_vld;
      w_ptr_d     = r_ptr;
      w_wrap      = 1'b0;
      if (w_ahb_acc) begin
         for (int l = 0; l < int'(RATIO); l++) begin
            if (r_ptr == PTR_W'(l)) begin
               w_pack_data[l*AHB_DW +: AHB_DW] = i_sdma_ahbrdata;
               w_pack_vld[l*AHB_BW +: AHB_BW]  = i_sdma_ahbrvld;
            end
         end
         w_wrap  = (r_ptr == PTR_W'(RATIO - 1));
         w_ptr_d = w_wrap ? '0 : r_ptr + 1'b1;
      end

      w_ending    = ((r_state == StRun) && i_flush) || (r_state == StDrain);
      w_part_push = w_ending && (w_ptr_d != '0) && (r_count < 2'd2);
      w_push      = (w_accept && !w_is_ahb) || w_wrap || w_part_push;
      w_push_data = w_is_ahb ? w_pack_data : w_c_data;
      w_push_vld  = w_is_ahb ? w_pack_vld : w_c_vld;
      w_pop       = (r_count != 2'd0) && i_sdma_sportready;
   end

   always_comb begin
      w_state_d   = r_state;
      o_sdma_done = 1'b0;
      unique case (r_state)
         StIdle:  if (w_start_ok) w_state_d = StRun;
         StRun:   if (i_flush) w_state_d = StDrain;
         StDrain: begin
            if ((r_ptr == '0) && (r_count == 2'd0)) begin
               o_sdma_done = 1'b1;
               w_state_d   = StIdle;
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= StIdle;
         r_pid       <= '0;
         r_ptr       <= '0;
         r_pack_data <= '0;
         r_pack_vld  <= '0;
         r_wr        <= 1'b0;
         r_rd        <= 1'b0;
         r_count     <= 2'd0;
         r_iderr     <= 1'b0;
         r_fifo_data <= '{default: '0};
         r_fifo_vld  <= '{default: '0};
      end else begin
         r_state <= w_state_d;
         r_iderr <= (r_state == StIdle) && i_start && !w_id_legal;
         if (w_start_ok) begin
            r_pid       <= i_inst_srcportid;
            r_ptr       <= '0;
            r_pack_data <= '0;
            r_pack_vld  <= '0;
         end else if (w_wrap || w_part_push) begin
            r_ptr       <= '0;
            r_pack_data <= '0;
            r_pack_vld  <= '0;
         end else if (w_ahb_acc) begin
            r_ptr       <= w_ptr_d;
            r_pack_data <= w_pack_data;
            r_pack_vld  <= w_pack_vld;
         end
         if (w_push) begin
            r_fifo_data[r_wr] <= w_push_data;
            r_fifo_vld[r_wr]  <= w_push_vld;
            r_wr              <= ~r_wr;
         end
         if (w_pop) r_rd <= ~r_rd;
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_sdma_sportvalid = (r_count != 2'd0);
   assign o_sdma_sportrdata = o_sdma_sportvalid ? r_fifo_data[r_rd] : '0;
   assign o_sdma_sportrvld  = o_sdma_sportvalid ? r_fifo_vld[r_rd] : '0;
   assign o_sdma_busy       = (r_state != StIdle);
   assign o_sdma_iderr      = r_iderr;

endmodule

// File: tb/tb_sdma_rdata_pack.sv
// Self-checking bench for sdma_rdata_pack: transaction-level model compared every
// cycle, plus literal expectations for the directed scenarios.
module tb_sdma_rdata_pack;

   localparam int RATIO = 4;
   localparam int NPORT = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [2:0]   pid = '0;
   logic         flush = 1'b0;
   logic [31:0]  ahb_d = '0;
   logic [3:0]   ahb_v = '0;
   logic [511:0] c_d = '0;
   logic [63:0]  c_v = '0;
   logic         ready = 1'b1;
   logic         o_rrdy, o_valid, o_busy, o_done, o_iderr;
   logic [127:0] o_data;
   logic [15:0]  o_rvld;

   sdma_rdata_pack dut (
      .i_clk             (clk),
      .i_rst             (rst),
      .i_start           (start),
      .i_inst_srcportid  (pid),
      .i_flush           (flush),
      .i_sdma_ahbrdata   (ahb_d),
      .i_sdma_ahbrvld    (ahb_v),
      .i_sdma_crdata     (c_d),
      .i_sdma_crvld      (c_v),
      .o_sdma_rrdy       (o_rrdy),
      .o_sdma_sportrdata (o_data),
      .o_sdma_sportrvld  (o_rvld),
      .o_sdma_sportvalid (o_valid),
      .i_sdma_sportready (ready),
      .o_sdma_busy       (o_busy),
      .o_sdma_done       (o_done),
      .o_sdma_iderr      (o_iderr)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail = 0;
   int done_cnt = 0;
   int iderr_cnt = 0;
   bit [127:0] cap_d[$];
   bit [15:0]  cap_v[$];

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Transaction-level model: phase 0 idle, 1 run, 2 drain; lanes collected as a list.
   bit         m_init = 0;
   int         m_phase = 0;
   int         m_pid = 0;
   bit         m_iderr = 0;
   bit [31:0]  ld[RATIO];
   bit [3:0]   lv[RATIO];
   int         nl = 0;
   bit [127:0] mq_d[$];
   bit [15:0]  mq_v[$];
   int         sz;
   bit         space, pop, have_push, src_any;
   bit [127:0] pd;
   bit [15:0]  pv;

   function automatic bit legal(input int p);
      return (p == 0) || (p >= 4 && p < 4 + NPORT);
   endfunction

   task automatic make_word(output bit [127:0] d, output bit [15:0] v);
      d = '0;
      v = '0;
      for (int l = 0; l < nl; l++) begin
         d[l*32 +: 32] = ld[l];
         v[l*4 +: 4]   = lv[l];
      end
   endtask

   always @(posedge clk) begin
      if (rst) begin
         m_init = 1;
         m_phase = 0;
         nl = 0;
         m_iderr = 0;
         mq_d.delete();
         mq_v.delete();
      end else if (m_init) begin
         sz = mq_d.size();
         space = (sz < 2);
         pop = (sz > 0) && ready;
         have_push = 0;
         m_iderr = 0;
         if (m_pid == 0) src_any = |ahb_v;
         else src_any = |c_v[(m_pid-4)*16 +: 16];
         case (m_phase)
            0: if (start) begin
               if (legal(int'(pid))) begin
                  m_phase = 1;
                  m_pid = int'(pid);
                  nl = 0;
               end else m_iderr = 1;
            end
            1: begin
               if (space && src_any) begin
                  if (m_pid == 0) begin
                     ld[nl] = ahb_d;
                     lv[nl] = ahb_v;
                     nl++;
                     if (nl == RATIO) begin
                        make_word(pd, pv);
                        have_push = 1;
                        nl = 0;
                     end
                  end else begin
                     pd = c_d[(m_pid-4)*128 +: 128];
                     pv = c_v[(m_pid-4)*16 +: 16];
                     have_push = 1;
                  end
               end
               if (flush) begin
                  if (nl > 0 && space) begin
                     make_word(pd, pv);
                     have_push = 1;
                     nl = 0;
                  end
                  m_phase = 2;
               end
            end
            default: begin
               if (nl > 0) begin
                  if (space) begin
                     make_word(pd, pv);
                     have_push = 1;
                     nl = 0;
                  end
               end else if (sz == 0) m_phase = 0;
            end
         endcase
         if (pop) begin
            void'(mq_d.pop_front());
            void'(mq_v.pop_front());
         end
         if (have_push) begin
            mq_d.push_back(pd);
            mq_v.push_back(pv);
         end
      end
   end

   always @(negedge clk) begin
      if (m_init) begin
         check("sportvalid", o_valid, mq_d.size() != 0);
         if (mq_d.size() != 0) begin
            check("sportrdata", o_data, mq_d[0]);
            check("sportrvld", o_rvld, mq_v[0]);
         end
         check("rrdy", o_rrdy, (m_phase == 1) && (mq_d.size() < 2));
         check("busy", o_busy, m_phase != 0);
         check("done", o_done, (m_phase == 2) && (nl == 0) && (mq_d.size() == 0));
         check("iderr", o_iderr, m_iderr);
         if (o_done) done_cnt++;
         if (o_iderr) iderr_cnt++;
         if (o_valid && ready) begin
            cap_d.push_back(o_data);
            cap_v.push_back(o_rvld);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [2:0] id);
      pid = id;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic ahb_beat(input logic [31:0] d, input logic fl);
      int g;
      g = 0;
      ahb_d = d;
      ahb_v = 4'hF;
      while (!o_rrdy && g < 50) begin
         tick();
         g++;
      end
      flush = fl;
      tick();
      flush = 1'b0;
      ahb_v = '0;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int d0;
      int g;
      d0 = done_cnt;
      g = 0;
      while (done_cnt == d0 && g < 40) begin
         tick();
         g++;
      end
      check(name, done_cnt - d0, 1);
      tick();
   endtask

   task automatic clear_cap();
      cap_d.delete();
      cap_v.delete();
   endtask

   function automatic bit [127:0] cword(input int i);
      return {32'hC5000000 + i, 32'h5A5A5A5A, 32'hA5A5A5A5, 32'h00000010 + i};
   endfunction

   task automatic set_cbeat(input int i);
      c_d[255:128] = cword(i);
      c_v[31:16]   = 16'hFFFF;
      c_d[127:0]   = {$urandom, $urandom, $urandom, $urandom};
      c_v[15:0]    = 16'hFFFF;
   endtask

   initial begin
      int i;
      int g;
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int i;
      int g;
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      check("reset_valid", o_valid, 0);
      check("reset_data", o_data, 0);
      check("reset_rvld", o_rvld, 0);
      check("reset_rrdy", o_rrdy, 0);
      check("reset_busy", o_busy, 0);
      tick();

      // Illegal id pulses iderr once and stays idle.
      do_start(3'b010);
      repeat (3) tick();
      check("iderr_pulses", iderr_cnt, 1);
      check("iderr_busy", o_busy, 0);

      // Four AHB beats pack into one full word.
      clear_cap();
      do_start(3'd0);
      ahb_beat(32'h11111111, 1'b0);
      ahb_beat(32'h22222222, 1'b0);
      ahb_beat(32'h33333333, 1'b0);
      ahb_beat(32'h44444444, 1'b0);
      repeat (3) tick();
      do_flush();
      wait_done("full_done");
      check("full_cnt", cap_d.size(), 1);
      if (cap_d.size() > 0) begin
         check("full_word", cap_d[0], 128'h44444444_33333333_22222222_11111111);
         check("full_rvld", cap_v[0], 16'hFFFF);
      end

      // Partial word emitted on flush.
      clear_cap();
      do_start(3'd0);
      ahb_beat(32'hAAAA0001, 1'b0);
      ahb_beat(32'hAAAA0002, 1'b0);
      do_flush();
      wait_done("part_done");
      check("part_cnt", cap_d.size(), 1);
      if (cap_d.size() > 0) begin
         check("part_word", cap_d[0], 128'h00000000_00000000_AAAA0002_AAAA0001);
         check("part_rvld", cap_v[0], 16'h00FF);
      end

      // Cache port 1 with backpressure; port 0 noise must be ignored.
      clear_cap();
      ready = 1'b0;
      do_start(3'd5);
      i = 0;
      g = 0;
      while (o_rrdy && i < 4 && g < 20) begin
         set_cbeat(i);
         tick();
         i++;
         g++;
      end
      check("stall_accepted", i, 2);
      check("stall_rrdy", o_rrdy, 0);
      for (int k = 0; k < 3; k++) begin
         set_cbeat(i);
         tick();
      end
      ready = 1'b1;
      g = 0;
      while (i < 4 && g < 40) begin
         set_cbeat(i);
         if (o_rrdy) i++;
         tick();
         g++;
      end
      c_v = '0;
      repeat (4) tick();
      do_flush();
      wait_done("cache_done");
      check("cache_cnt", cap_d.size(), 4);
      for (int k = 0; k < 4; k++)
         if (k < cap_d.size()) check("cache_word", cap_d[k], cword(k));

      // Reset mid-transfer with one FIFO entry.
      clear_cap();
      ready = 1'b0;
      do_start(3'd4);
      c_d[127:0] = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
      c_v[15:0] = 16'hFFFF;
      tick();
      c_v = '0;
      check("pre_rst_valid", o_valid, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_valid", o_valid, 0);
      check("rst_busy", o_busy, 0);
      check("rst_rrdy", o_rrdy, 0);
      ready = 1'b1;
      tick();
      do_start(3'd4);
      c_d[127:0] = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
      c_v[15:0] = 16'h0F0F;
      tick();
      c_v = '0;
      do_flush();
      wait_done("rst_restart_done");
      check("rst_restart_cnt", cap_d.size(), 1);
      if (cap_d.size() > 0) begin
         check("rst_restart_word", cap_d[0], 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
         check("rst_restart_rvld", cap_v[0], 16'h0F0F);
      end

      // Wrap beat together with flush: one full word only.
      clear_cap();
      do_start(3'd0);
      ahb_beat(32'h01010101, 1'b0);
      ahb_beat(32'h02020202, 1'b0);
      ahb_beat(32'h03030303, 1'b0);
      ahb_beat(32'h04040404, 1'b1);
      wait_done("wrapflush_done");
      repeat (3) tick();
      check("wrapflush_cnt", cap_d.size(), 1);
      if (cap_d.size() > 0) begin
         check("wrapflush_word", cap_d[0], 128'h04040404_03030303_02020202_01010101);
         check("wrapflush_rvld", cap_v[0], 16'hFFFF);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sdma_rdata_pack.md
# sdma_rdata_pack

Registered source-port read-data steering and width-packing stage between the SDMA source ports (AHB and NPORT cache ports) and the SDMA write side. Selects one source per transfer from the instruction's source port id. Packs narrow AHB beats into full cache-width words and passes cache beats straight through. Buffers output in a 2-entry FIFO with valid/ready backpressure.

## Interface
Parameters:
- AHB_DW, 32, AHB read-data width; CACHE_DW % AHB_DW == 0
- CACHE_DW, 128, cache/output data width
- NPORT, 4, cache ports, 1..4; cache port k has id 4+k
- PID_W, 3, source port id width

Ports:
- i_clk  in  1  clock; one clock domain
- i_rst  in  1  reset; synchronous, active-high
- i_start  in  1  pulse; latches i_inst_srcportid and begins a transfer
- i_inst_srcportid  in  PID_W  0 = AHB, 4+k = cache port k
- i_flush  in  1  pulse; ends the transfer and emits any partial packed word
- i_sdma_ahbrdata  in  AHB_DW  AHB read data
- i_sdma_ahbrvld  in  AHB_DW/8  AHB byte valids; beat present when any bit is set
- i_sdma_crdata  in  NPORT*CACHE_DW  cache read data, port k at slice k
- i_sdma_crvld  in  NPORT*CACHE_DW/8  cache byte valids, port k at slice k
- o_sdma_rrdy  out  1  beat acceptance ready to the selected source
- o_sdma_sportrdata  out  CACHE_DW  FIFO head data
- o_sdma_sportrvld  out  CACHE_DW/8  FIFO head byte valids
- o_sdma_sportvalid  out  1  FIFO head valid
- i_sdma_sportready  in  1  consumer ready
- o_sdma_busy  out  1  high when the FSM is not in IDLE
- o_sdma_done  out  1  one-cycle pulse when the transfer completes
- o_sdma_iderr  out  1  one-cycle pulse when i_start carries an illegal id

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE to RUN:
  - On i_start with a legal id (0, or 4..4+NPORT-1).
  - Latches the id and clears the pack pointer and the pack register.
- IDLE, illegal id:
  - o_sdma_iderr pulses for one cycle.
  - The FSM stays in IDLE.
- i_start outside IDLE: ignored.
- RUN:
  - o_sdma_rrdy = (fifo_count < 2). It is 0 in IDLE and DRAIN.
  - A beat is accepted when the selected source has any valid bit set and o_sdma_rrdy = 1.
  - The source must hold an unaccepted beat. Unselected sources are ignored.
- Cache id:
  - Each accepted beat's data and valids are pushed to the FIFO unchanged.
- AHB id:
  - An accepted beat is written into lane ptr of the pack register (bits ptr*AHB_DW up), with its valids at lane ptr.
  - ptr increments modulo RATIO = CACHE_DW/AHB_DW.
  - When ptr wraps, the packed word is pushed and the pack register is cleared.
  - Unwritten lanes carry valid = 0 and data = 0.
- i_flush in RUN:
  - A beat accepted in the same cycle is included first.
  - The FSM then goes to DRAIN.
- DRAIN:
  - If a partial packed word exists (ptr != 0 after that beat), it is pushed once FIFO space exists.
  - Once the FIFO is empty, o_sdma_done pulses and the FSM returns to IDLE.
- FIFO: 2 entries.
  - Push and pop in the same cycle when full is legal; the count is unchanged.
  - Pop occurs when o_sdma_sportvalid & i_sdma_sportready.
- Reset values:
  - FSM = IDLE, ptr = 0, FIFO empty.
  - All outputs are 0: data, rvld, sportvalid, rrdy, busy, done, iderr.
- Reset mid-transfer discards the FIFO and the pack register contents.

## Timing
- Cache beat accepted in cycle t: o_sdma_sportvalid = 1 in t+1 if the FIFO was empty.
- AHB: the RATIO-th beat accepted in cycle t gives output valid in t+1.
- Flush in t with a partial word and FIFO space: word valid in t+1. o_sdma_done follows the cycle after the FIFO drains.
- Output is registered from the FIFO head with no combinational path from sources.
- o_sdma_rrdy is combinational from fifo_count and state only, not from i_sdma_sportready.
- Sustained throughput:
  - 1 cache beat per cycle while i_sdma_sportready = 1.
  - AHB: 1 output word per RATIO beats.

## Test plan
- Reset, then idle: all outputs 0. i_start with id 3'b010 gives o_sdma_iderr pulsed for 1 cycle and busy stays 0.
- id 0, AHB beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 with vld 4'hF, ready=1:
  - One word 0x44444444_33333333_22222222_11111111 with rvld 16'hFFFF.
  - Then flush gives done with no extra word.
- id 0, two AHB beats 0xAAAA0001, 0xAAAA0002, then flush: word 0x00000000_00000000_AAAA0002_AAAA0001 with rvld 16'h00FF, then done.
- id 5 (cache port 1), 4 back-to-back beats with ready held 0:
  - rrdy drops after 2 accepted.
  - Port 0 data toggling is ignored.
  - Releasing ready delivers all 4 in order, exactly once.
- id 4, i_rst asserted mid-transfer with 1 FIFO entry present:
  - Next cycle: sportvalid=0, busy=0, rrdy=0.
  - New start works normally.
- id 0, RATIO-th beat and i_flush in the same cycle: exactly one full word, no empty word, then done.
